rr_enc_arbiter: RTL and testbench

Round-robin arbiter that shares the 8-input, 3-bit-output encoder resource among eight requesters. Each request line maps to one encoder input bit `d[i]`. The block grants exactly one requester at a time, holds the grant while that requester keeps its request high, and rotates priority so that the most recently served requester has the lowest priority. Its `gnt` bus drives the encoder's `d`, and `gnt_id` carries the same 3-bit index the encoder produces.

---
 rtl/rr_enc_arbiter.sv | 139 +++++++++++++
 tb/tb_rr_enc_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rr_enc_arbiter.sv
// rr_enc_arbiter: round-robin arbiter granting one of eight requesters to a shared 8:3 encoder.
// Optional forced release after MAX_HOLD cycles when RR_ENC_ARB_TIMEOUT_EN is defined. Rev 1.0
`default_nettype none

module rr_enc_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_req,
    output logic [7:0] o_gnt,
    output logic [2:0] o_gnt_id,
    output logic       o_gnt_vld,
    output logic       o_tmo
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t     r_state;
    logic [2:0] r_ptr;
    logic [7:0] r_gnt;
    logic [2:0] r_gnt_id;
    logic       r_gnt_vld;

    logic       w_any;
    logic [2:0] w_pick;
    logic       w_drop;

    assign w_any  = |i_req;
    assign w_drop = ~i_req[r_gnt_id];

    // Scan from the far end back toward r_ptr so the nearest set bit in search order wins.
    always_comb begin
        w_pick = r_ptr;
        for (int i = 7; i >= 0; i--) begin
            if (i_req[r_ptr + 3'(i)]) begin
                w_pick = r_ptr + 3'(i);
            end
        end
    end

`ifdef RR_ENC_ARB_TIMEOUT_EN
    localparam logic [7:0] c_hold_last = 8'(MAX_HOLD - 1);

    logic [7:0] r_hold;
    logic       r_tmo;
    logic       w_tmo_hit;

    // r_hold counts completed BUSY cycles, so the MAX_HOLD-th cycle sees MAX_HOLD-1.
    assign w_tmo_hit = (r_hold >= c_hold_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= 3'd0;
            r_gnt     <= 8'h00;
            r_gnt_id  <= 3'd0;
            r_gnt_vld <= 1'b0;
            r_hold    <= 8'd0;
            r_tmo     <= 1'b0;
        end else begin
            r_tmo <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_hold <= 8'd0;
                    if (w_any) begin
                        r_state   <= S_BUSY;
                        r_gnt     <= 8'h01 << w_pick;
                        r_gnt_id  <= w_pick;
                        r_gnt_vld <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (w_drop || w_tmo_hit) begin
                        r_state   <= S_IDLE;
                        r_gnt     <= 8'h00;
                        r_gnt_vld <= 1'b0;
                        r_ptr     <= r_gnt_id + 3'd1;
                        r_hold    <= 8'd0;
                        r_tmo     <= ~w_drop;
                    end else if (r_hold != 8'hFF) begin
                        r_hold <= r_hold + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_tmo = r_tmo;
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= 3'd0;
            r_gnt     <= 8'h00;
            r_gnt_id  <= 3'd0;
            r_gnt_vld <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state   <= S_BUSY;
                        r_gnt     <= 8'h01 << w_pick;
                        r_gnt_id  <= w_pick;
                        r_gnt_vld <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (w_drop) begin
                        r_state   <= S_IDLE;
                        r_gnt     <= 8'h00;
                        r_gnt_vld <= 1'b0;
                        r_ptr     <= r_gnt_id + 3'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // MAX_HOLD only matters with the timeout compiled in; both arms are zero.
    assign o_tmo = (MAX_HOLD == 0) ? 1'b0 : 1'b0;
`endif

    assign o_gnt     = r_gnt;
    assign o_gnt_id  = r_gnt_id;
    assign o_gnt_vld = r_gnt_vld;

endmodule

`default_nettype wire

// File: tb/tb_rr_enc_arbiter.sv
// tb_rr_enc_arbiter: directed self-checking bench for rr_enc_arbiter (MAX_HOLD=4).
// Rev 1.0
`default_nettype none

module tb_rr_enc_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_vld;
    logic       tmo;

    int checks   = 0;
    int failures = 0;

    rr_enc_arbiter #(.MAX_HOLD(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (req),
        .o_gnt    (gnt),
        .o_gnt_id (gnt_id),
        .o_gnt_vld(gnt_vld),
        .o_tmo    (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] e_gnt, input logic [2:0] e_id,
                           input logic e_tmo);
        chk({tag, ".gnt"},     32'(gnt),     32'(e_gnt));
        chk({tag, ".gnt_id"},  32'(gnt_id),  32'(e_id));
        chk({tag, ".gnt_vld"}, 32'(gnt_vld), 32'(e_gnt != 8'h00));
        chk({tag, ".tmo"},     32'(tmo),     32'(e_tmo));
    endtask

    initial begin
        int hold_cycles;
        rst_n = 1'b0;
        req   = 8'hFF;

        // Reset held with all requests high
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("reset", 8'h00, 3'd0, 1'b0);
        end
        rst_n = 1'b1;
        tick();
        chk_all("first_grant", 8'h01, 3'd0, 1'b0);

        // Rotation 0..7,0 with an IDLE cycle between grants
        for (int k = 0; k < 8; k++) begin
            req = 8'hFF;
            tick();
            chk_all("rot_hold", 8'(1 << k), 3'(k), 1'b0);
            req = 8'hFF & ~8'(1 << k);
            tick();
            chk_all("rot_idle", 8'h00, 3'(k), 1'b0);
            req = 8'hFF;
            tick();
            chk_all("rot_next", 8'(1 << ((k + 1) % 8)), 3'((k + 1) % 8), 1'b0);
        end

        // Wrap / pointer: serve 6, then 0x41 must pick 0
        req = 8'h00;
        tick();
        chk_all("wrap_rel0", 8'h00, 3'd0, 1'b0);
        req = 8'h40;
        tick();
        chk_all("wrap_g6", 8'h40, 3'd6, 1'b0);
        req = 8'h00;
        tick();
        chk_all("wrap_rel6", 8'h00, 3'd6, 1'b0);
        req = 8'h41;
        tick();
        chk_all("wrap_g0", 8'h01, 3'd0, 1'b0);
        req = 8'h00;
        tick();
        chk_all("wrap_rel0b", 8'h00, 3'd0, 1'b0);
        req = 8'h40;
        tick();
        chk_all("wrap_g6b", 8'h40, 3'd6, 1'b0);
        req = 8'h00;
        tick();
        chk_all("wrap_rel6b", 8'h00, 3'd6, 1'b0);

        // Hold / ignore other requesters while index 3 is granted
        req = 8'h08;
        tick();
        chk_all("hold_g3", 8'h08, 3'd3, 1'b0);
`ifdef RR_ENC_ARB_TIMEOUT_EN
        hold_cycles = 2;
`else
        hold_cycles = 20;
`endif
        for (int i = 0; i < hold_cycles; i++) begin
            req = 8'h08 | (8'($urandom) & 8'hF0);
            tick();
            chk_all("hold_keep", 8'h08, 3'd3, 1'b0);
        end
        req = 8'h00;
        tick();
        chk_all("hold_rel", 8'h00, 3'd3, 1'b0);

        // Timeout behaviour with req=0x0C (ptr=4 so index 2 wins first)
        req = 8'h0C;
        tick();
        chk_all("tmo_g2", 8'h04, 3'd2, 1'b0);
`ifdef RR_ENC_ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("tmo_hold2", 8'h04, 3'd2, 1'b0);
        end
        tick();
        chk_all("tmo_pulse2", 8'h00, 3'd2, 1'b1);
        tick();
        chk_all("tmo_g3", 8'h08, 3'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("tmo_hold3", 8'h08, 3'd3, 1'b0);
        end
        tick();
        chk_all("tmo_pulse3", 8'h00, 3'd3, 1'b1);
        tick();
        chk_all("tmo_g2b", 8'h04, 3'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("tmo_hold2b", 8'h04, 3'd2, 1'b0);
        end
        // Normal release on the timeout edge: no pulse
        req = 8'h00;
        tick();
        chk_all("tmo_tie_rel", 8'h00, 3'd2, 1'b0);
`else
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_all("notmo_hold", 8'h04, 3'd2, 1'b0);
        end
        req = 8'h00;
        tick();
        chk_all("notmo_rel", 8'h00, 3'd2, 1'b0);
`endif
        tick();
        chk_all("idle_quiet", 8'h00, 3'd2, 1'b0);

        // Mid-grant reset
        req = 8'h20;
        tick();
        chk_all("mid_g5", 8'h20, 3'd5, 1'b0);
        tick();
        chk_all("mid_g5_hold", 8'h20, 3'd5, 1'b0);
        rst_n = 1'b0;
        req   = 8'h21;
        tick();
        chk_all("mid_rst", 8'h00, 3'd0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_all("mid_g0", 8'h01, 3'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
